// File: rtl/wb_uart_rx.sv
// rtl/wb_uart_rx.sv - Wishbone-slave 8N1 UART receiver with a small receive FIFO
module wb_uart_rx #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int RESET_DIVIDER = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     uart_rx_i,
    input  logic [WB_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_we_i,
    input  logic                     wb_cyc_i,
    input  logic                     wb_stb_i,
    output logic                     wb_ack_o,
    output logic [WB_DATA_WIDTH-1:0] wb_data_o,
    output logic                     irq_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0] SANITY_VALUE = 32'hA17EB0B1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state_q, state_n;
    logic [1:0]         sync_q;
    logic               rxs;
    logic [1:0]         warm_q;
    logic               armed_q;
    logic [31:0]        divider_q;
    logic [31:0]        period, half;
    logic [31:0]        cnt_q;
    logic [2:0]         bitidx_q;
    logic [7:0]         shreg_q;
    logic               cnt_clr, shift_en, frame_ok, frame_bad;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               full, not_empty, push, pop;
    logic               overrun_q, ferr_q, irq_q;
    logic               ack_q;
    logic [WB_DATA_WIDTH-1:0] rdata_q, rd_mux;
    logic               accept, rd_acc, wr_acc;
    logic [1:0]         reg_sel;
    logic [31:0]        count_ext;
    logic               unused_bits;

    assign rxs       = sync_q[1];
    assign period    = divider_q + 32'd2;
    assign half      = period >> 1;
    assign reg_sel   = wb_addr_i[3:2];
    assign accept    = wb_cyc_i & wb_stb_i & ~ack_q;
    assign rd_acc    = accept & ~wb_we_i;
    assign wr_acc    = accept & wb_we_i;
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop       = rd_acc && (reg_sel == 2'd1) && not_empty;
    assign push      = frame_ok & (~full | pop);
    assign count_ext = 32'(count_q);
    assign unused_bits = ^{wb_sel_i, wb_addr_i[WB_ADDR_WIDTH-1:4], wb_addr_i[1:0], count_ext[31:4], half[31]};

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], uart_rx_i};
    end

    // After reset, wait until the synchroniser reflects the real line and it is seen high,
    // so a reset released in the middle of a frame cannot fake a start bit
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            warm_q  <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
            if (warm_q == 2'd2 && rxs) armed_q <= 1'b1;
        end
    end

    // Receiver state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_n;
    end

    // Receiver next-state and per-cycle datapath controls
    always_comb begin
        state_n   = state_q;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (armed_q && !rxs) begin
                    state_n = S_START;
                    cnt_clr = 1'b1;
                end
            end
            S_START: begin
                if (cnt_q == half - 32'd1) begin
                    cnt_clr = 1'b1;
                    state_n = rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == period - 32'd1) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bitidx_q == 3'd7) state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == period - 32'd1) begin
                    cnt_clr = 1'b1;
                    if (rxs) begin
                        frame_ok = 1'b1;
                        state_n  = S_IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_n   = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    cnt_clr = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Bit timer, bit index and LSB-first shift register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= 32'd0;
            bitidx_q <= 3'd0;
            shreg_q  <= 8'd0;
        end else begin
            cnt_q <= cnt_clr ? 32'd0 : cnt_q + 32'd1;
            if (state_q == S_START) bitidx_q <= 3'd0;
            if (shift_en) begin
                shreg_q[bitidx_q] <= rxs;
                bitidx_q          <= bitidx_q + 3'd1;
            end
        end
    end

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= shreg_q;
    end

    // FIFO pointers, occupancy and the registered interrupt
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
            irq_q <= not_empty;
        end
    end

    // Divider and sticky error flags; a set event wins over a software clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            divider_q <= 32'(RESET_DIVIDER);
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            if (wr_acc && reg_sel == 2'd0) divider_q <= 32'(wb_data_i);
            if (frame_ok && full && !pop)
                overrun_q <= 1'b1;
            else if (wr_acc && reg_sel == 2'd2 && wb_data_i[2])
                overrun_q <= 1'b0;
            if (frame_bad)
                ferr_q <= 1'b1;
            else if (wr_acc && reg_sel == 2'd2 && wb_data_i[3])
                ferr_q <= 1'b0;
        end
    end

    // Register read multiplexer
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            2'd0: rd_mux = WB_DATA_WIDTH'(divider_q);
            2'd1: rd_mux = not_empty ? WB_DATA_WIDTH'(mem_q[rd_ptr_q]) : '0;
            2'd2: rd_mux = WB_DATA_WIDTH'({count_ext[3:0], ferr_q, overrun_q, full, not_empty});
            default: rd_mux = WB_DATA_WIDTH'(SANITY_VALUE);
        endcase
    end

    // Single-cycle acknowledge with registered read data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= accept;
            rdata_q <= rd_acc ? rd_mux : '0;
        end
    end

    assign wb_ack_o  = ack_q & wb_cyc_i;
    assign wb_data_o = wb_ack_o ? rdata_q : '0;
    assign irq_o     = irq_q;

endmodule

// File: doc/wb_uart_rx.md
Name: wb_uart_rx

Overview:
- Wishbone-slave UART receiver; the receive-side counterpart of the team's wb_uart transmitter.
- Samples the serial line, deserialises 8N1 frames and buffers received bytes in a small FIFO.
- Exposes divider, data, status and sanity registers to the CPU over Wishbone.
- Bit timing matches the transmitter exactly: one bit period is P = divider + 2 clocks.

Parameters:
WB_DATA_WIDTH, 32, Wishbone data width
WB_ADDR_WIDTH, 32, Wishbone address width
WB_SEL_WIDTH, WB_DATA_WIDTH/8, byte-select width
FIFO_DEPTH, 4, receive FIFO entries; power of two, 2..16
RESET_DIVIDER, 1, divider value after reset

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active-low
uart_rx_i  in  1  serial input, idle high, asynchronous to clk_i
wb_addr_i  in  WB_ADDR_WIDTH  address; bits [3:2] select the register
wb_data_i  in  WB_DATA_WIDTH  write data
wb_sel_i  in  WB_SEL_WIDTH  byte selects (ignored; full-word access)
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_ack_o  out  1  acknowledge
wb_data_o  out  WB_DATA_WIDTH  read data
irq_o  out  1  high while the FIFO is non-empty

Behaviour:
- Reset (rst_ni low, async) values:
  - ack=0, wb_data_o=0, irq_o=0.
  - divider=RESET_DIVIDER; FIFO empty; overrun=0; ferr=0.
  - FSM=IDLE; synchroniser flops=1.
- Synchroniser: uart_rx_i passes through 2 flops; rxs denotes the synced value. All FSM decisions use rxs.
- Timing: P = divider+2 clocks (32-bit add, wrap ignored). H = P>>1. Counter cnt is 32 bits and clears on every state entry.
- FSM:
  - IDLE: rxs==0 -> START.
  - START: when cnt==H-1, sample rxs. 0 -> DATA with bitidx=0. 1 -> IDLE (glitch rejected, no flag).
  - DATA: when cnt==P-1, shift rxs into bit[bitidx] (LSB first) and clear cnt. After bit 7 -> STOP.
  - STOP: when cnt==P-1, sample rxs.
    - 1: push the byte if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise set overrun sticky and drop the byte. Then -> IDLE.
    - 0: set ferr sticky, discard the byte -> BREAK.
  - BREAK: wait for rxs==1 -> IDLE. A held-low line therefore produces exactly one framing error.
- Sampling point: each bit is sampled mid-bit at (k+1)*P + H - 1 clocks after the start edge reaches rxs, k = 0..8.
- Divider writes take effect immediately, including mid-frame. Mid-frame divider change is software's responsibility; no protection.
- Wishbone (classic):
  - Access is accepted when cyc & stb & !ack_q. On that edge ack_q<=1 and the read data is registered.
  - Next edge: ack_q<=0. wb_ack_o = ack_q & wb_cyc_i, giving a 1-cycle ack per access.
  - wb_data_o = 0 outside ack cycles.
- Register map (addr[3:2]):
  - 0 DIVIDER: RW.
  - 1 DATA: RO. Returns {0, head byte} and pops on the accept edge. If empty, returns 0 and does not pop. Writes ignored, acked.
  - 2 STATUS: RO. Bit0 not-empty, bit1 full, bit2 overrun, bit3 ferr, bits[7:4] count (zero-extended/truncated). Write with data bit2/bit3 set clears that sticky. A set event in the same cycle wins over the clear.
  - 3 SANITY: RO, 32'hA17EB0B1. Writes ignored.
  - Every access is acked, including writes to read-only registers.
- FIFO:
  - Circular buffer with wrapping pointers and a count register.
  - Push and pop in the same cycle: both occur, count unchanged. When empty, a pop is suppressed and a push lands normally.
- irq_o = registered (count != 0). Updates the cycle after the push or pop.
- Back-to-back frames: a new start bit is detected in IDLE one cycle after STOP exits. Zero idle time between frames is supported.

Test Plan:
- Reset: drive rst_ni low mid-frame, release -> DIVIDER reads 1, STATUS reads 0, SANITY reads 0xA17EB0B1, irq_o=0, FSM ignores the remainder of the frame until it sees an idle-high line.
- Single frame: divider=6 (P=8), send 0x5A as 8N1 at 8 clocks/bit -> irq_o rises. STATUS=0x11. DATA read returns 0x5A, after which STATUS=0x00 and irq_o falls.
- Loopback: tie the wb_uart transmitter's uart_tx_o to uart_rx_i, both dividers=6, transmit 0x00, 0xFF, 0xA5, 0x3C -> all four read back in order.
- Overrun: divider=2, send 5 frames 0x01..0x05 without reading -> STATUS bit1=1, bit2=1, count=4. Reads return 0x01..0x04, then 0 when empty. Writing 0x4 to STATUS clears bit2.
- Framing/break: send 0x55 with stop bit=0, then hold the line low for 100 clocks, then high -> ferr set exactly once, FIFO empty. The next valid 0x33 frame is received correctly.
- Glitch and simultaneous events: a 2-clock low pulse on the line -> nothing pushed. With the FIFO full, a DATA read on the same edge as a STOP push -> count stays 4, no overrun.
